// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit: shift modes and FSM states.
package shift_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts WIDTH bits by 0..STEP in the given mode.
// With SHIFT_FLAGS_EN defined it also reports the last bit shifted out.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 8,
  parameter int unsigned AmtW  = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AmtW-1:0]  amt_i,
  input  logic [1:0]       mode_i,
  input  logic             fill_i,
`ifdef SHIFT_FLAGS_EN
  output logic             carry_o,
`endif
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    unique case (mode_i)
      MODE_SLL: data_o = data_i << amt_i;
      MODE_SRL: data_o = data_i >> amt_i;
      MODE_SRA: data_o = WIDTH'({{WIDTH{fill_i}}, data_i} >> amt_i);
      MODE_ROR: data_o = WIDTH'({data_i, data_i} >> amt_i);
      default:  data_o = data_i;
    endcase
  end

`ifdef SHIFT_FLAGS_EN
  // A zero-bit guard next to the data makes amt_i == 0 report no carry.
  always_comb begin
    carry_o = 1'b0;
    if (mode_i == MODE_SLL) begin
      carry_o = 1'(({1'b0, data_i} << amt_i) >> WIDTH);
    end else begin
      carry_o = 1'({data_i, 1'b0} >> amt_i);
    end
  end
`endif

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift unit (SLL/SRL/SRA/ROR) stepping at most STEP bits per cycle.
// Define SHIFT_FLAGS_EN to add the carry_out and zero result flags.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SHIFT_FLAGS_EN
  output logic             carry_out,
  output logic             zero,
`endif
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned AmtW = $clog2(STEP + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [1:0]       mode_q, mode_d;
  logic [CntW-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [CntW-1:0]  n_amt;
  logic [AmtW-1:0]  step_amt;
  logic             last_step;
  logic [WIDTH-1:0] step_data;
  logic             step_fill;

`ifdef SHIFT_FLAGS_EN
  logic carry_q, carry_d;
  logic zero_q, zero_d;
  logic step_carry;
`endif

  // Linear shifts saturate at WIDTH; rotate wraps modulo WIDTH.
  always_comb begin
    if (mode == MODE_ROR) begin
      n_amt = CntW'(B % WIDTH'(WIDTH));
    end else if (B >= WIDTH'(WIDTH)) begin
      n_amt = CntW'(WIDTH);
    end else begin
      n_amt = CntW'(B);
    end
  end

  assign last_step = (rem_q <= CntW'(STEP));
  assign step_amt  = last_step ? AmtW'(rem_q) : AmtW'(STEP);
  // SRA never changes the accumulator MSB, so it still holds the original sign.
  assign step_fill = (mode_q == MODE_SRA) & acc_q[WIDTH-1];

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AmtW  (AmtW)
  ) u_step (
    .data_i  (acc_q),
    .amt_i   (step_amt),
    .mode_i  (mode_q),
    .fill_i  (step_fill),
`ifdef SHIFT_FLAGS_EN
    .carry_o (step_carry),
`endif
    .data_o  (step_data)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    result_d = result_q;
`ifdef SHIFT_FLAGS_EN
    carry_d  = carry_q;
    zero_d   = zero_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          acc_d  = A;
          mode_d = mode;
          rem_d  = n_amt;
          if (n_amt == '0) begin
            state_d  = StDone;
            result_d = A;
`ifdef SHIFT_FLAGS_EN
            carry_d  = 1'b0;
            zero_d   = (A == '0);
`endif
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        acc_d = step_data;
        rem_d = rem_q - CntW'(step_amt);
        if (last_step) begin
          state_d  = StDone;
          result_d = step_data;
`ifdef SHIFT_FLAGS_EN
          carry_d  = step_carry;
          zero_d   = (step_data == '0);
`endif
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mode_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
`ifdef SHIFT_FLAGS_EN
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      result_q <= result_d;
`ifdef SHIFT_FLAGS_EN
      carry_q  <= carry_d;
      zero_q   <= zero_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
`ifdef SHIFT_FLAGS_EN
  assign carry_out = carry_q;
  assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed scoreboard bench for iter_shift_unit; flag checks follow SHIFT_FLAGS_EN.
module tb_iter_shift_unit;
  import shift_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned S = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [1:0]   mode_in = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
`ifdef SHIFT_FLAGS_EN
  logic         carry_out;
  logic         zero;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_res_q[$];
  int           exp_lat_q[$];
  logic         exp_c_q[$];

  iter_shift_unit #(
    .WIDTH (W),
    .STEP  (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .mode      (mode_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SHIFT_FLAGS_EN
    .carry_out (carry_out),
    .zero      (zero),
`endif
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-at-a-time reference model.
  task automatic model(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c, output int lat);
    int n;
    if (m == MODE_ROR) n = int'(b % W);
    else if (b >= W) n = W;
    else n = int'(b);
    r = a;
    c = 1'b0;
    for (int i = 0; i < n; i++) begin
      case (m)
        MODE_SLL: begin c = r[W-1]; r = {r[W-2:0], 1'b0}; end
        MODE_SRL: begin c = r[0];   r = {1'b0, r[W-1:1]}; end
        MODE_SRA: begin c = r[0];   r = {r[W-1], r[W-1:1]}; end
        default:  begin c = r[0];   r = {r[0], r[W-1:1]}; end
      endcase
    end
    lat = 1 + (n + S - 1) / S;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag, input bit release_out);
    logic [W-1:0] r;
    logic         c;
    int           lat;
    int           guard;
    model(m, a, b, r, c, lat);
    exp_res_q.push_back(r);
    exp_lat_q.push_back(lat);
    exp_c_q.push_back(c);
    a_in = a;
    b_in = b;
    mode_in = m;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    // Scramble inputs after acceptance; they must not matter.
    a_in = $urandom;
    b_in = $urandom;
    mode_in = 2'($urandom_range(0, 3));
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat_q.pop_front()));
    check({tag, " result"}, 64'(result), 64'(exp_res_q.pop_front()));
    c = exp_c_q.pop_front();
`ifdef SHIFT_FLAGS_EN
    check({tag, " carry"}, 64'(carry_out), 64'(c));
    check({tag, " zero"}, 64'(zero), 64'(r == '0));
`endif
    if (release_out) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " idle"}, 64'({in_ready, out_valid}), 64'b10);
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [1:0]   rm;

    repeat (2) tick();
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst result", 64'(result), 64'd0);
    rst = 1'b0;
    tick();
    check("post rst in_ready", 64'(in_ready), 64'd1);
    check("post rst out_valid", 64'(out_valid), 64'd0);

    do_op(MODE_SRL, 32'h8000_0000, 32'd4,  "srl4", 1'b1);
    do_op(MODE_SRA, 32'h8000_0000, 32'd40, "sra40", 1'b1);
    do_op(MODE_SRL, 32'h8000_0000, 32'd40, "srl40", 1'b1);
    do_op(MODE_ROR, 32'h1234_5678, 32'd36, "ror36", 1'b1);
    do_op(MODE_SLL, 32'hCAFE_F00D, 32'd0,  "sll0", 1'b1);
    do_op(MODE_SRL, 32'hCAFE_F00D, 32'd0,  "srl0", 1'b1);
    do_op(MODE_SRA, 32'hCAFE_F00D, 32'd0,  "sra0", 1'b1);
    do_op(MODE_ROR, 32'hCAFE_F00D, 32'd0,  "ror0", 1'b1);
    do_op(MODE_ROR, 32'h1234_5678, 32'd32, "ror32", 1'b1);
    do_op(MODE_SRA, 32'h7FFF_FFFF, 32'd33, "sra33", 1'b1);
    do_op(MODE_SLL, 32'h8000_0001, 32'd1,  "sll1", 1'b1);
    do_op(MODE_SRL, 32'h0000_0001, 32'd1,  "srl1", 1'b1);
    do_op(MODE_SLL, 32'h0000_000F, 32'd31, "sll31", 1'b1);
    do_op(MODE_SRA, 32'h8765_4321, 32'd17, "sra17", 1'b1);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = W'($urandom_range(0, 70));
      rm = 2'($urandom_range(0, 3));
      do_op(rm, ra, rb, "rand", 1'b1);
    end

    // Backpressure: result held, no second accept while DONE.
    do_op(MODE_SRL, 32'h8000_0000, 32'd4, "bp", 1'b0);
    a_in = 32'hDEAD_BEEF;
    b_in = 32'd3;
    mode_in = MODE_SLL;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp hold valid", 64'(out_valid), 64'd1);
      check("bp hold result", 64'(result), 64'h0800_0000);
      check("bp in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("bp release", 64'({in_ready, out_valid}), 64'b10);
    tick();
    check("bp no accept", 64'({in_ready, out_valid}), 64'b10);

    // Asynchronous reset after one shift cycle.
    a_in = 32'h00AB_CDEF;
    b_in = 32'd24;
    mode_in = MODE_SLL;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("mid in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort result", 64'(result), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b0;
    tick();
    check("abort stays idle", 64'({in_ready, out_valid}), 64'b10);
    do_op(MODE_SLL, 32'h00AB_CDEF, 32'd24, "after rst", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
- Parametrised multi-cycle shift unit for the ALU datapath.
- Generalises the fixed 32-bit logical right shift to any width and four modes: SLL, SRL, SRA and ROR.
- Shifts iteratively by at most STEP bits per cycle, reusing one small step shifter instead of a full barrel shifter.
- Valid/ready handshakes on input and output, so it sits between the register-read stage and the writeback mux.

Parameters:
WIDTH, 32, operand/result width; any value >= 2
STEP, 8, maximum bits shifted per cycle; power of two, 1..WIDTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands and mode presented
in_ready  output  1  unit can accept an operation
A  input  WIDTH  operand to shift
B  input  WIDTH  shift amount, full width, unsigned
mode  input  2  shift mode, encoding from package
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts the result
result  output  WIDTH  shifted value

Behaviour:
- Reset: state=IDLE, result=0, out_valid=0, internal regs=0. in_ready=1 once rst deasserts.
- in_ready = (state==IDLE), decoded from state only, never from in_valid.
- Effective amount n:
  - SLL/SRL/SRA: n = min(B, WIDTH). So B >= WIDTH gives 0 for SLL/SRL and all sign bits for SRA.
  - ROR: n = B mod WIDTH.
- IDLE: on in_valid & in_ready, register A into the accumulator and latch mode and n as the remaining count rem.
  - n==0 -> DONE.
  - else -> SHIFT.
- SHIFT: each cycle shift the accumulator by k = min(rem, STEP), then rem -= k.
  - Fill: SLL/SRL fill zeros; SRA fills the latched sign bit; ROR wraps.
  - When rem reaches 0, go to DONE.
- DONE: out_valid=1, result = accumulator, held stable.
  - On out_ready, go to IDLE and drop out_valid.
  - in_valid is ignored while in DONE: no overlap, no bypass.
- Latency, accept edge to out_valid: 1 + ceil(n/STEP) cycles.
  - Max 1 + WIDTH/STEP (5 at defaults).
  - n==0 gives 1 cycle.
- result updates only on entry to DONE and holds its last value in IDLE and SHIFT.
- Mode, A and B changes after acceptance have no effect.
- Async reset in any state aborts the operation immediately and applies all reset values. No partial result is ever flagged valid.
- out_ready while in IDLE or SHIFT is ignored.

Optional Feature:
- Macro: SHIFT_FLAGS_EN.
- Enabled: adds output ports carry_out (1) and zero (1), both valid with out_valid and reset to 0.
  - carry_out = last bit shifted out: MSB side for SLL, LSB side for SRL/SRA/ROR. It is 0 when n==0.
  - zero = (result == 0).
  - Both are held in DONE.
- Disabled: the ports do not exist and there is no flag logic.

Decomposition:
- Package shift_pkg holds:
  - mode constants MODE_SLL=2'b00, MODE_SRL=2'b01, MODE_SRA=2'b10, MODE_ROR=2'b11.
  - state encoding IDLE/SHIFT/DONE.
- Sub-module shift_step: combinational shift of WIDTH bits by 0..STEP, given mode and fill bit. Instantiated once.

Test Plan:
- SRL, A=0x80000000, B=4, STEP=8 -> result 0x08000000, out_valid 2 cycles after accept.
- SRA, A=0x80000000, B=40 -> n clamps to 32, result 0xFFFFFFFF, latency 5 cycles. SRL with the same operands -> 0x00000000.
- ROR, A=0x12345678, B=36 -> n=4, result 0x81234567. B=0, any mode -> result=A, latency 1.
- Backpressure: out_ready held low 3 cycles with in_valid=1 -> result and out_valid stable, in_ready=0, no second accept. out_ready=1 -> IDLE next cycle.
- Reset mid-SHIFT (SLL, B=24, rst pulsed after 1 shift cycle) -> out_valid=0, result=0, in_ready=1. The next operation completes correctly.
- SHIFT_FLAGS_EN cases:
  - SLL A=0x80000001, B=1 -> result 0x00000002, carry_out=1, zero=0.
  - SRL A=0x1, B=1 -> result 0, carry_out=1, zero=1.
